// File: rtl/bitclk_ratio_divider.sv
// rtl/bitclk_ratio_divider.sv - programmable integer divider of the bit-rate clock
// Registered divided clock with ratio changes applied only at period boundaries.
module bitclk_ratio_divider #(
    parameter int RATIO_W = 8
) (
    input  logic               Ref_Clk,
    input  logic               rst,
    input  logic [RATIO_W-1:0] div_ratio,
    output logic               divided_clk,
    output logic               div_pulse,
    output logic [RATIO_W-1:0] active_ratio
);

    logic [RATIO_W-1:0] r_cnt;
    logic [RATIO_W-1:0] r_ratio;
    logic               r_restart;
    logic               r_clk;
    logic               r_pulse;

    logic [RATIO_W-1:0] w_eff;
    logic [RATIO_W:0]   w_high_time;
    logic [RATIO_W-1:0] w_cnt_next;
    logic               w_wrap;

    // Ratios 0 and 1 cannot produce a clock; they fold onto divide-by-2.
    assign w_eff       = (div_ratio < RATIO_W'(2)) ? RATIO_W'(2) : div_ratio;
    assign w_high_time = ({1'b0, r_ratio} + (RATIO_W+1)'(1)) >> 1;
    assign w_cnt_next  = r_cnt + RATIO_W'(1);
    assign w_wrap      = r_restart || (r_cnt == (r_ratio - RATIO_W'(1)));

    always_ff @(posedge Ref_Clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_ratio   <= w_eff;
            r_restart <= 1'b1;
            r_clk     <= 1'b0;
            r_pulse   <= 1'b0;
        end else if (w_wrap) begin
            r_cnt     <= '0;
            r_ratio   <= w_eff;
            r_restart <= 1'b0;
            r_clk     <= 1'b1;
            r_pulse   <= 1'b1;
        end else begin
            r_cnt     <= w_cnt_next;
            r_clk     <= ({1'b0, w_cnt_next} < w_high_time);
            r_pulse   <= 1'b0;
        end
    end

    assign divided_clk  = r_clk;
    assign div_pulse    = r_pulse;
    assign active_ratio = r_ratio;

endmodule

// File: tb/tb_bitclk_ratio_divider.sv
// tb/tb_bitclk_ratio_divider.sv - scoreboard bench for bitclk_ratio_divider
// Reference model expands each period into its list of output samples.
module tb_bitclk_ratio_divider;

    localparam int RATIO_W = 8;

    typedef struct {
        logic             clk;
        logic             pulse;
        logic [RATIO_W-1:0] ratio;
    } exp_t;

    logic               clk = 1'b1;
    logic               rst = 1'b1;
    logic [RATIO_W-1:0] div_ratio = 8'd10;
    logic               divided_clk;
    logic               div_pulse;
    logic [RATIO_W-1:0] active_ratio;

    exp_t exp_q[$];
    logic period_q[$];
    logic [RATIO_W-1:0] m_ratio;
    logic m_first;

    int checks = 0;
    int errors = 0;
    int pushes = 0;
    int pops   = 0;

    bitclk_ratio_divider #(.RATIO_W(RATIO_W)) dut (
        .Ref_Clk     (clk),
        .rst         (rst),
        .div_ratio   (div_ratio),
        .divided_clk (divided_clk),
        .div_pulse   (div_pulse),
        .active_ratio(active_ratio)
    );

    always #5 clk = ~clk;

    function automatic logic [RATIO_W-1:0] eff(input logic [RATIO_W-1:0] x);
        return (x < 2) ? RATIO_W'(2) : x;
    endfunction

    // Model: a new period of N samples is generated whenever the previous one is used up.
    task automatic model_step(input logic r, input logic [RATIO_W-1:0] x);
        exp_t e;
        if (r) begin
            period_q.delete();
            m_ratio = eff(x);
            e.clk = 1'b0; e.pulse = 1'b0; e.ratio = m_ratio;
        end else begin
            m_first = 1'b0;
            if (period_q.size() == 0) begin
                int n;
                m_ratio = eff(x);
                n = int'(m_ratio);
                for (int i = 0; i < n; i++) period_q.push_back(i < (n + 1) / 2);
                m_first = 1'b1;
            end
            e.clk = period_q.pop_front();
            e.pulse = m_first;
            e.ratio = m_ratio;
        end
        exp_q.push_back(e);
        pushes++;
    endtask

    task automatic cycle(input logic r, input logic [RATIO_W-1:0] x);
        @(negedge clk);
        rst = r;
        div_ratio = x;
        model_step(r, x);
    endtask

    task automatic run(input logic [RATIO_W-1:0] x, input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, x);
    endtask

    task automatic do_reset(input logic [RATIO_W-1:0] x, input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, x);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                pops++;
                checks++;
                if (divided_clk !== e.clk) begin
                    errors++;
                    $display("FAIL divided_clk t=%0t got %b want %b", $time, divided_clk, e.clk);
                end
                checks++;
                if (div_pulse !== e.pulse) begin
                    errors++;
                    $display("FAIL div_pulse t=%0t got %b want %b", $time, div_pulse, e.pulse);
                end
                checks++;
                if (active_ratio !== e.ratio) begin
                    errors++;
                    $display("FAIL active_ratio t=%0t got %0d want %0d", $time, active_ratio, e.ratio);
                end
            end
        end
    end

    initial begin : stimulus
        logic [RATIO_W-1:0] r;
        do_reset(8'd10, 3);
        run(8'd10, 60);
        do_reset(8'd20, 1);
        run(8'd20, 110);
        do_reset(8'd40, 1);
        run(8'd40, 210);
        do_reset(8'd7, 1);
        run(8'd7, 40);
        do_reset(8'd255, 1);
        run(8'd255, 520);
        // Ratio change three cycles into a divide-by-10 period
        do_reset(8'd10, 1);
        run(8'd10, 23);
        run(8'd20, 60);
        do_reset(8'd0, 1);
        run(8'd0, 10);
        run(8'd1, 10);
        // One-cycle reset inside the high phase
        do_reset(8'd10, 1);
        run(8'd10, 12);
        do_reset(8'd10, 1);
        run(8'd10, 25);
        r = 8'd5;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0)
                r = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 24));
            if ($urandom_range(0, 299) == 0) cycle(1'b1, r);
            else cycle(1'b0, r);
        end
        @(posedge clk);
        #2;
        checks++;
        if (pops != pushes || exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d popped want %0d", pops, pushes);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
